// File: rtl/alu_sequencer.sv
// alu_sequencer: runs 8-bit ops as two nibble passes through an external 4-bit ALU (optional ALU_SEQ_ACC_EN adds in_acc).
module alu_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] in_op,
  input  logic [7:0] in_a,
  input  logic [7:0] in_b,
`ifdef ALU_SEQ_ACC_EN
  input  logic       in_acc,
`endif
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic       alu_a_inv,
  output logic       alu_b_inv,
  output logic       alu_c_in,
  output logic [1:0] alu_op,
  input  logic [3:0] alu_result,
  input  logic       alu_n,
  input  logic       alu_c,
  input  logic       alu_v,
  input  logic       alu_z,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] result,
  output logic       flag_n,
  output logic       flag_c,
  output logic       flag_v,
  output logic       flag_z
);
  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;
  state_t state_q, state_d;
  logic [2:0] op_q;
  logic [7:0] a_q, b_q, result_q, opa, sum;
  logic [3:0] lo_q, an, bn;
  logic lc_q, n_q, c_q, v_q, z_q;
  logic busy, hi, arith, sub, nota;
  always_ff @(posedge clk) state_q <= rst ? IDLE : state_d;
  always_comb begin
    state_d = state_q == IDLE ? (in_valid ? LO : IDLE) :
              state_q == LO   ? HI :
              state_q == HI   ? DONE :
              (out_ready ? IDLE : DONE);
  end
  always_comb begin
    in_ready  = state_q == IDLE;
    out_valid = state_q == DONE;
    busy      = state_q == LO || state_q == HI;
    hi        = state_q == HI;
    arith     = ~op_q[2];
    sub       = op_q[2:1] == 2'b01;
    nota      = op_q == 3'b111;
    an        = hi ? a_q[7:4] : a_q[3:0];
    bn        = hi ? b_q[7:4] : b_q[3:0];
    alu_a     = busy ? an : 4'h0;
    alu_b     = (busy && !nota) ? (sub ? ~bn : bn) : 4'h0;
    alu_a_inv = busy && nota;
    alu_b_inv = 1'b0;
    alu_op    = !busy ? 2'b00 : arith ? 2'b11 : nota ? 2'b01 : op_q[1:0];
    // low pass: ADD 0, ADC stored carry, SUB/CMP 1 (two's complement), logic 0
    alu_c_in  = busy && (hi ? lc_q : arith && (op_q[1] || (op_q[0] && c_q)));
    sum       = {alu_result, lo_q};
`ifdef ALU_SEQ_ACC_EN
    opa       = in_acc ? result_q : in_a;
`else
    opa       = in_a;
`endif
  end
  always_ff @(posedge clk) begin
    if (in_ready && in_valid) begin
      op_q <= in_op;
      a_q  <= opa;
      b_q  <= in_b;
    end
    if (state_q == LO) begin
      lo_q <= alu_result;
      lc_q <= alu_c;
    end
    if (rst) begin
      result_q <= 8'h00;
      {n_q, c_q, v_q, z_q} <= 4'b0000;
    end else if (hi) begin
      if (op_q != 3'b011) result_q <= sum;
      n_q <= sum[7];
      z_q <= sum == 8'h00;
      c_q <= arith && alu_c;
      v_q <= arith && alu_v;
    end
  end
  assign result = result_q;
  assign flag_n = n_q;
  assign flag_c = c_q;
  assign flag_v = v_q;
  assign flag_z = z_q;
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed checks of alu_sequencer against a behavioural 4-bit ALU.
module tb_alu_sequencer;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0;
  logic [2:0] in_op = 0;
  logic [7:0] in_a = 0, in_b = 0;
  logic in_ready, out_valid, alu_a_inv, alu_b_inv, alu_c_in;
  logic [3:0] alu_a, alu_b, m_r, ea, eb;
  logic [1:0] alu_op;
  logic [4:0] s;
  logic m_c, m_v;
  logic [7:0] result;
  logic flag_n, flag_c, flag_v, flag_z;
  int total = 0, bad = 0;
  logic lo_cin;
  logic [3:0] lo_b;
  logic lo_ainv;
  always #5 clk = ~clk;
  alu_sequencer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b),
`ifdef ALU_SEQ_ACC_EN
    .in_acc(1'b0),
`endif
    .alu_a(alu_a), .alu_b(alu_b), .alu_a_inv(alu_a_inv), .alu_b_inv(alu_b_inv),
    .alu_c_in(alu_c_in), .alu_op(alu_op), .alu_result(m_r), .alu_n(m_r[3]),
    .alu_c(m_c), .alu_v(m_v), .alu_z(m_r == 4'h0), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .flag_n(flag_n), .flag_c(flag_c),
    .flag_v(flag_v), .flag_z(flag_z));
  always_comb begin
    ea = alu_a_inv ? ~alu_a : alu_a;
    eb = alu_b_inv ? ~alu_b : alu_b;
    s = {1'b0, ea} + {1'b0, eb} + {4'b0, alu_c_in};
    m_r = alu_op == 2'b00 ? ea & eb : alu_op == 2'b01 ? ea | eb : alu_op == 2'b10 ? ea ^ eb : s[3:0];
    m_c = alu_op == 2'b11 && s[4];
    m_v = alu_op == 2'b11 && ea[3] == eb[3] && s[3] != ea[3];
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // accept a request, check LO/HI timing, leave the DUT sitting in DONE
  task automatic run(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    in_op = op; in_a = a; in_b = b; in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    lo_cin = alu_c_in; lo_b = alu_b; lo_ainv = alu_a_inv;
    chk("lo_busy", {in_ready, out_valid}, 2'b00);
    chk("lo_alu_a", alu_a, a[3:0]);
    @(negedge clk);
    chk("hi_not_valid", out_valid, 1'b0);
    chk("hi_alu_a", alu_a, a[7:4]);
    @(negedge clk);
    chk("done_valid", out_valid, 1'b1);
    chk("done_alu_idle", {alu_a, alu_b, alu_op, alu_c_in, alu_a_inv}, 12'h0);
  endtask
  task automatic release_out();
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    chk("back_idle", {in_ready, out_valid}, 2'b10);
  endtask
  task automatic res(input string tag, input logic [7:0] r, input logic [3:0] nczv);
    chk(tag, {result, flag_n, flag_c, flag_v, flag_z}, {r, nczv});
  endtask
  initial begin
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("reset_ready", {in_ready, out_valid}, 2'b10);
    res("reset_regs", 8'h00, 4'b0000);
    chk("idle_alu_zero", {alu_a, alu_b, alu_op, alu_c_in, alu_a_inv, alu_b_inv}, 13'h0);
    run(3'b000, 8'h3C, 8'h05);
    chk("add_cin", lo_cin, 1'b0);
    res("add_3c_05", 8'h41, 4'b0000);
    release_out();
    run(3'b000, 8'hFF, 8'h01);
    res("add_ff_01", 8'h00, 4'b0101);
    release_out();
    run(3'b001, 8'h10, 8'h20);
    chk("adc_cin", lo_cin, 1'b1);
    res("adc_10_20", 8'h31, 4'b0000);
    release_out();
    run(3'b010, 8'h50, 8'h60);
    chk("sub_cin", lo_cin, 1'b1);
    chk("sub_binv", lo_b, 4'hF);
    res("sub_50_60", 8'hF0, 4'b1000);
    release_out();
    run(3'b000, 8'h7F, 8'h01);
    res("add_7f_01", 8'h80, 4'b1010);
    release_out();
    run(3'b011, 8'h22, 8'h22);
    res("cmp_22_22", 8'h80, 4'b0101);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_valid", out_valid, 1'b1);
      res("hold_regs", 8'h80, 4'b0101);
    end
    release_out();
    run(3'b111, 8'h0F, 8'h33);
    chk("nota_ctl", {lo_ainv, lo_b}, 5'b10000);
    res("nota_0f", 8'hF0, 4'b1000);
    release_out();
    run(3'b110, 8'hAA, 8'hAA);
    res("xor_aa_aa", 8'h00, 4'b0001);
    release_out();
    @(negedge clk);
    in_op = 3'b000; in_a = 8'h12; in_b = 8'h34; in_valid = 1;
    @(negedge clk);
    in_op = 3'b110; in_a = 8'hFF; in_b = 8'hFF;
    @(negedge clk);
    in_valid = 0;
    chk("lo_ignore_valid", {in_ready, alu_a, alu_op}, {1'b0, 4'h1, 2'b11});
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("rst_hi_ready", {in_ready, out_valid}, 2'b10);
    res("rst_hi_regs", 8'h00, 4'b0000);
    run(3'b001, 8'h01, 8'h01);
    chk("adc_after_rst_cin", lo_cin, 1'b0);
    res("adc_after_rst", 8'h02, 4'b0000);
    release_out();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have port clk, input, 1, single system clock, rising-edge active.
REQ-002 SHALL have port rst, input, 1, reset: synchronous, active-high.
REQ-003 SHALL have port in_valid, input, 1, request valid.
REQ-004 SHALL have port in_ready, output, 1, sequencer idle and accepting a request.
REQ-005 SHALL have port in_op, input, 3: 000 ADD, 001 ADC, 010 SUB, 011 CMP, 100 AND, 101 OR, 110 XOR, 111 NOTA.
REQ-006 SHALL have ports in_a and in_b, input, 8 each, operands.
REQ-007 SHALL have ports alu_a and alu_b, output, 4 each, nibble operands to the 4-bit ALU.
REQ-008 SHALL have ports alu_a_inv, alu_b_inv, alu_c_in, output, 1 each, and alu_op, output, 2 (00 AND, 01 OR, 10 XOR, 11 SUM), ALU controls.
REQ-009 SHALL have ports alu_result, input, 4, and alu_n, alu_c, alu_v, alu_z, input, 1 each, ALU returns.
REQ-010 SHALL have ports out_valid, output, 1, and out_ready, input, 1, result handshake.
REQ-011 SHALL have ports result, output, 8, and flag_n, flag_c, flag_v, flag_z, output, 1 each, registered.

Function
REQ-012 SHALL implement FSM IDLE -> LO -> HI -> DONE -> IDLE; in_ready=1 only in IDLE.
REQ-013 SHALL accept a request on the edge where in_valid and in_ready are both 1, latching in_op, in_a, in_b, and SHALL ignore in_valid in all other states.
REQ-014 SHALL, in LO, drive the low nibbles and capture alu_result and alu_c at the end of the cycle; in HI, drive the high nibbles with alu_c_in equal to the captured low carry.
REQ-015 SHALL, in LO, drive alu_c_in as: ADD 0, ADC stored flag_c, SUB/CMP 1, logic ops 0.
REQ-016 SHALL, for SUB/CMP, drive alu_b with the bitwise-inverted nibble, alu_b_inv=0, alu_op=11.
REQ-017 SHALL, for NOTA, drive alu_a_inv=1, alu_b=0, alu_op=01; all other ops drive alu_a_inv=0, alu_b_inv=0.
REQ-018 SHALL assert out_valid on the second rising edge after acceptance (DONE) and hold it, with result and flags stable, until out_ready=1; IDLE follows the next edge.
REQ-019 SHALL set flags for arithmetic ops: flag_c = HI alu_c, flag_v = HI alu_v, flag_n = result bit 7, flag_z = (8-bit result == 0).
REQ-020 SHALL set flags for logic ops: flag_n = bit 7, flag_z = (result == 0), flag_c = 0, flag_v = 0.
REQ-021 SHALL, for CMP, update flags only; result retains its previous value.
REQ-022 SHALL keep result and flags unchanged outside DONE entry; flag_c persists between operations for ADC.
REQ-023 SHALL drive all alu_* outputs to 0 in IDLE and DONE.

Reset
REQ-024 SHALL, on rst=1 at a rising edge in any state, enter IDLE, discard any in-flight operation, and clear result, all flags, and out_valid to 0.
REQ-025 SHALL present in_ready=1 on the first edge after rst deasserts.

Configuration
REQ-026 SHALL, with ALU_SEQ_ACC_EN defined, add input port in_acc (1 bit); when in_acc=1 at acceptance, operand A is the current result register instead of in_a.
REQ-027 SHALL, without ALU_SEQ_ACC_EN, omit in_acc, and operand A SHALL always be in_a.

Verification
REQ-028 SHALL cover: ADD 0x3C+0x05 -> result 0x41, N0 C0 V0 Z0, out_valid on 2nd edge after accept.
REQ-029 SHALL cover: ADD 0xFF+0x01 -> 0x00, C1 Z1 V0 N0; then ADC 0x10+0x20 -> 0x31, C0.
REQ-030 SHALL cover: SUB 0x50-0x60 -> 0xF0, N1 C0 V0 Z0; ADD 0x7F+0x01 -> 0x80, N1 V1.
REQ-031 SHALL cover: result 0x80 then CMP 0x22,0x22 -> Z1 C1, result stays 0x80; out_ready held 0 for 3 cycles -> out_valid and result stable.
REQ-032 SHALL cover: NOTA 0x0F -> 0xF0, N1 C0 V0; XOR 0xAA,0xAA -> 0x00, Z1.
REQ-033 SHALL cover: rst asserted in HI -> next edge out_valid 0, in_ready 1, result 0x00, flags 0; in_valid during LO ignored.
